// File: rtl/ddr3_app_tg_if.sv
// DDR3 controller user (app) interface: command, write-data and read-return channels.
// The traffic generator drives the master side; the controller or a model sits on the slave side.
interface ddr3_app_tg_if #(
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned APP_DATA_WIDTH = 512,
  parameter int unsigned APP_MASK_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr3_app_tg.sv
// DDR3 app-interface traffic generator: writes a per-pass pattern to a block of addresses,
// reads it back in order and counts miscompares; a read-idle timeout also flags an error.
module ddr3_app_tg #(
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned APP_DATA_WIDTH = 512,
  parameter int unsigned APP_MASK_WIDTH = 64,
  parameter int unsigned BURST_COUNT    = 256,
  parameter int unsigned ADDR_STEP      = 8,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_calib_complete,
  input  logic          start,
  ddr3_app_tg_if.master app,
  output logic          busy,
  output logic          done,
  output logic          tg_compare_error,
  output logic [15:0]   err_count,
  output logic [15:0]   pass_count
);

  localparam int unsigned Lanes = APP_DATA_WIDTH / 32;
  localparam int unsigned IdxW  = 17;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0]       BurstLen = IdxW'(BURST_COUNT);
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(BURST_COUNT - 1);
  localparam logic [TmoW-1:0]       TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] Base     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] Step     = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [2:0]            CmdWrite = 3'b000;
  localparam logic [2:0]            CmdRead  = 3'b001;

  typedef enum logic [2:0] {StIdle, StWaitCal, StWrite, StRead, StDrain, StDone} state_e;

  state_e          state_q;
  logic            start_q;
  logic [IdxW-1:0] cmd_idx_q;
  logic [IdxW-1:0] rd_idx_q;
  logic [TmoW-1:0] tmo_q;

  logic cmd_ok, wd_ok, rd_hit, rd_miss, tmo_hit;
  logic unused_rd_end;

  // Every 32-bit lane k carries {pass byte, index, lane number}.
  function automatic logic [APP_DATA_WIDTH-1:0] pattern(input logic [7:0]  pass_byte,
                                                        input logic [15:0] idx);
    logic [APP_DATA_WIDTH-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < Lanes; k++) begin
      p[32*k +: 32] = {pass_byte, idx, 8'(k)};
    end
    return p;
  endfunction

  assign app.app_wdf_end  = app.app_wdf_wren;
  assign app.app_wdf_mask = '0;
  assign unused_rd_end    = app.app_rd_data_end;

  always_comb begin
    // A channel counts as complete once its valid is low or is being accepted this cycle.
    cmd_ok  = !app.app_en || app.app_rdy;
    wd_ok   = !app.app_wdf_wren || app.app_wdf_rdy;
    rd_hit  = ((state_q == StRead) || (state_q == StDrain)) && app.app_rd_data_valid &&
              (rd_idx_q != BurstLen);
    rd_miss = rd_hit && (app.app_rd_data != pattern(pass_count[7:0], rd_idx_q[15:0]));
    // An accepted read command also restarts the idle count.
    tmo_hit = (tmo_q == TmoLast) && !app.app_rd_data_valid &&
              !((state_q == StRead) && app.app_rdy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      start_q          <= 1'b0;
      cmd_idx_q        <= '0;
      rd_idx_q         <= '0;
      tmo_q            <= '0;
      app.app_addr     <= '0;
      app.app_cmd      <= CmdWrite;
      app.app_en       <= 1'b0;
      app.app_wdf_data <= '0;
      app.app_wdf_wren <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      tg_compare_error <= 1'b0;
      err_count        <= '0;
      pass_count       <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;

      if (rd_hit) begin
        rd_idx_q <= rd_idx_q + 1'b1;
        if (rd_miss) begin
          tg_compare_error <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end

      case (state_q)
        StIdle: begin
          if (start_q) begin
            state_q <= StWaitCal;
            busy    <= 1'b1;
          end
        end

        StWaitCal: begin
          if (init_calib_complete) begin
            state_q          <= StWrite;
            cmd_idx_q        <= '0;
            rd_idx_q         <= '0;
            app.app_en       <= 1'b1;
            app.app_cmd      <= CmdWrite;
            app.app_addr     <= Base;
            app.app_wdf_wren <= 1'b1;
            app.app_wdf_data <= pattern(pass_count[7:0], 16'd0);
          end
        end

        StWrite: begin
          if (cmd_ok && wd_ok) begin
            if (cmd_idx_q == LastIdx) begin
              state_q          <= StRead;
              cmd_idx_q        <= '0;
              tmo_q            <= '0;
              app.app_en       <= 1'b1;
              app.app_cmd      <= CmdRead;
              app.app_addr     <= Base;
              app.app_wdf_wren <= 1'b0;
            end else begin
              cmd_idx_q        <= cmd_idx_q + 1'b1;
              app.app_en       <= 1'b1;
              app.app_addr     <= app.app_addr + Step;
              app.app_wdf_wren <= 1'b1;
              app.app_wdf_data <= pattern(pass_count[7:0], cmd_idx_q[15:0] + 16'd1);
            end
          end else begin
            app.app_en       <= app.app_en && !app.app_rdy;
            app.app_wdf_wren <= app.app_wdf_wren && !app.app_wdf_rdy;
          end
        end

        StRead: begin
          if (tmo_hit) begin
            state_q          <= StDone;
            app.app_en       <= 1'b0;
            tg_compare_error <= 1'b1;
          end else begin
            tmo_q <= (app.app_rd_data_valid || app.app_rdy) ? '0 : tmo_q + 1'b1;
            if (app.app_rdy) begin
              if (cmd_idx_q == LastIdx) begin
                state_q    <= StDrain;
                app.app_en <= 1'b0;
              end else begin
                cmd_idx_q    <= cmd_idx_q + 1'b1;
                app.app_addr <= app.app_addr + Step;
              end
            end
          end
        end

        StDrain: begin
          if (rd_idx_q == BurstLen) begin
            state_q <= StDone;
          end else if (tmo_hit) begin
            state_q          <= StDone;
            tg_compare_error <= 1'b1;
          end else begin
            tmo_q <= app.app_rd_data_valid ? '0 : tmo_q + 1'b1;
          end
        end

        StDone: begin
          state_q    <= StIdle;
          busy       <= 1'b0;
          done       <= 1'b1;
          pass_count <= pass_count + 16'd1;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_app_tg.sv
// Randomized scoreboard bench for ddr3_app_tg against a loopback memory model; expected command,
// data and end-of-pass status are queued when a pass is launched and popped by a monitor.
module tb_ddr3_app_tg;
  localparam int unsigned AW    = 29;
  localparam int unsigned DW    = 64;
  localparam int unsigned MW    = 8;
  localparam int unsigned BC    = 4;
  localparam int unsigned STEP  = 8;
  localparam int unsigned TMO   = 16;
  localparam int unsigned LANES = DW / 32;

  logic        clk = 1'b0;
  logic        rst_n, calib, start, busy, done, tg_err;
  logic [15:0] err_count, pass_count;

  ddr3_app_tg_if #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) app ();

  ddr3_app_tg #(
    .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .BURST_COUNT(BC),
    .ADDR_STEP(STEP), .BASE_ADDR(0), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .start(start), .app(app),
    .busy(busy), .done(done), .tg_compare_error(tg_err), .err_count(err_count),
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct { int unsigned pass; int unsigned err; logic flag; } st_t;
  typedef struct { int unsigned due; logic [AW-1:0] addr; } rd_t;

  cmd_t            exp_cmd[$];
  logic [DW-1:0]   exp_wd[$];
  st_t             exp_st[$];
  logic [AW-1:0]   waddr_q[$];
  logic [DW-1:0]   wdata_q[$];
  rd_t             rdq[$];
  logic [DW-1:0]   mem[logic [AW-1:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned ref_pass, ref_err;
  logic        ref_flag;
  bit rand_rdy, bp_mode, flip_mode, noret_mode;
  int unsigned ret_cnt, bp_cnt, n_done, done_cyc, last_rd_acc, en8_cnt, wren_cnt;
  logic prev_done;
  cmd_t          mon_c;
  st_t           mon_s;
  logic [DW-1:0] mon_d, drv_d;
  logic [AW-1:0] drv_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=event-missing-or-extra required=matching-expectation", name);
  endtask

  // Lane k of word idx in pass p: {p mod 256, idx mod 65536, k}.
  function automatic logic [DW-1:0] ref_pat(input int unsigned pass, input int unsigned idx);
    logic [DW-1:0] p;
    int unsigned   w;
    p = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w = ((pass % 256) << 24) | ((idx % 65536) << 8) | k;
      p[32*k +: 32] = w;
    end
    return p;
  endfunction

  task automatic push_pass(input bit flip, input bit noret);
    for (int unsigned i = 0; i < BC; i++) begin
      exp_cmd.push_back('{3'b000, AW'(i * STEP)});
      exp_wd.push_back(ref_pat(ref_pass, i));
    end
    for (int unsigned i = 0; i < BC; i++) exp_cmd.push_back('{3'b001, AW'(i * STEP)});
    if (noret) ref_flag = 1'b1;
    if (flip) begin
      ref_flag = 1'b1;
      if (ref_err < 65535) ref_err++;
    end
    ref_pass = (ref_pass + 1) % 65536;
    exp_st.push_back('{ref_pass, ref_err, ref_flag});
  endtask

  task automatic flush();
    exp_cmd.delete(); exp_wd.delete(); exp_st.delete();
    waddr_q.delete(); wdata_q.delete(); rdq.delete(); mem.delete();
    ref_pass = 0; ref_err = 0; ref_flag = 1'b0; ret_cnt = 0; bp_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    flush();
    rst_n = 1'b1;
  endtask

  task automatic start_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (n_done == n0) fail_event({name, "_done_timeout"});
    check({name, "_cmds_left"}, 64'(exp_cmd.size()), 64'd0);
    check({name, "_wdata_left"}, 64'(exp_wd.size()), 64'd0);
  endtask

  // Scoreboard monitor: handshakes seen here complete at the following rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (app.app_en && app.app_rdy) begin
        if (exp_cmd.size() == 0) fail_event("cmd_unexpected");
        else begin
          mon_c = exp_cmd.pop_front();
          check("cmd_type", 64'(app.app_cmd), 64'(mon_c.cmd));
          check("cmd_addr", 64'(app.app_addr), 64'(mon_c.addr));
        end
        if (app.app_cmd == 3'b001 && app.app_addr == AW'((BC - 1) * STEP)) last_rd_acc = cycle + 1;
      end
      if (app.app_wdf_wren && app.app_wdf_rdy) begin
        check("wdf_end", 64'(app.app_wdf_end), 64'd1);
        if (exp_wd.size() == 0) fail_event("wdata_unexpected");
        else begin
          mon_d = exp_wd.pop_front();
          check("wdata", 64'(app.app_wdf_data), 64'(mon_d));
        end
      end
      if (bp_mode && app.app_en && app.app_cmd == 3'b000 && app.app_addr == AW'(STEP)) en8_cnt++;
      if (bp_mode && app.app_wdf_wren) wren_cnt++;
      if (prev_done) check("done_width", 64'(done), 64'd0);
      if (done) begin
        n_done++;
        done_cyc = cycle;
        check("busy_at_done", 64'(busy), 64'd0);
        if (exp_st.size() == 0) fail_event("done_unexpected");
        else begin
          mon_s = exp_st.pop_front();
          check("pass_count", 64'(pass_count), 64'(mon_s.pass));
          check("err_count", 64'(err_count), 64'(mon_s.err));
          check("compare_error", 64'(tg_err), 64'(mon_s.flag));
        end
      end
      prev_done = done;
    end
  end

  // Loopback memory: pair accepted write addresses with data beats; schedule read returns.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (app.app_en && app.app_rdy) begin
        if (app.app_cmd == 3'b000) waddr_q.push_back(app.app_addr);
        else rdq.push_back('{cycle + 2 + $urandom_range(3), app.app_addr});
      end
      if (app.app_wdf_wren && app.app_wdf_rdy) wdata_q.push_back(app.app_wdf_data);
      while (waddr_q.size() > 0 && wdata_q.size() > 0) mem[waddr_q.pop_front()] = wdata_q.pop_front();
    end
  end

  // Ready and read-return driver, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      app.app_wdf_rdy = 1'b1;
      if (app.app_en && app.app_cmd == 3'b000 && app.app_addr == AW'(STEP)) begin
        bp_cnt++;
        app.app_rdy = (bp_cnt > 3);
      end else app.app_rdy = 1'b1;
    end else if (rand_rdy) begin
      app.app_rdy     = ($urandom_range(3) != 0);
      app.app_wdf_rdy = ($urandom_range(3) != 0);
    end else begin
      app.app_rdy     = 1'b1;
      app.app_wdf_rdy = 1'b1;
    end
    app.app_rd_data_valid = 1'b0;
    app.app_rd_data_end   = 1'b0;
    if (!noret_mode && rdq.size() > 0 && rdq[0].due <= cycle &&
        (!rand_rdy || $urandom_range(3) != 0)) begin
      drv_a = rdq[0].addr;
      rdq.pop_front();
      drv_d = mem.exists(drv_a) ? mem[drv_a] : '0;
      if (flip_mode && ret_cnt == 2) drv_d[0] = ~drv_d[0];
      ret_cnt++;
      app.app_rd_data       = drv_d;
      app.app_rd_data_valid = 1'b1;
      app.app_rd_data_end   = 1'b1;
    end
  end

  initial begin
    int lat, en_seen;
    int unsigned saved_done;
    rst_n = 1'b0; calib = 1'b0; start = 1'b0;
    app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0; app.app_rd_data = '0;
    app.app_rd_data_valid = 1'b0; app.app_rd_data_end = 1'b0;
    rand_rdy = 0; bp_mode = 0; flip_mode = 0; noret_mode = 0;
    n_done = 0; done_cyc = 0; last_rd_acc = 0; en8_cnt = 0; wren_cnt = 0; prev_done = 1'b0;

    // Reset values
    do_reset(5);
    @(negedge clk);
    check("rst_app_en", 64'(app.app_en), 64'd0);
    check("rst_wren", 64'(app.app_wdf_wren), 64'd0);
    check("rst_wdf_end", 64'(app.app_wdf_end), 64'd0);
    check("rst_mask", 64'(app.app_wdf_mask), 64'd0);
    check("rst_cmd", 64'(app.app_cmd), 64'd0);
    check("rst_addr", 64'(app.app_addr), 64'd0);
    check("rst_wdata", 64'(app.app_wdf_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flag", 64'(tg_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_pass_count", 64'(pass_count), 64'd0);

    // Calibration gating
    push_pass(0, 0);
    start_pass();
    en_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (app.app_en) en_seen++;
    end
    check("cal_gate_en", 64'(en_seen), 64'd0);
    check("cal_gate_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 calib = 1'b1;
    @(negedge clk);
    check("cal_en_before_edge", 64'(app.app_en), 64'd0);
    @(negedge clk);
    check("cal_first_en", 64'(app.app_en), 64'd1);
    check("cal_first_addr", 64'(app.app_addr), 64'd0);
    wait_done("calpass");

    // Start latency and second-pass pattern byte, all ready signals high
    push_pass(0, 0);
    start_pass();
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (app.app_en) break;
      lat++;
    end
    check("start_latency", 64'(lat), 64'd2);
    check("lane0_top_byte", 64'(app.app_wdf_data[31:24]), 64'h01);
    wait_done("clean");

    // Random backpressure on all channels and random read return gaps
    rand_rdy = 1;
    repeat (4) begin
      push_pass(0, 0);
      ret_cnt = 0;
      start_pass();
      wait_done("random");
    end

    // Directed command backpressure on write 1
    rand_rdy = 0; bp_mode = 1; bp_cnt = 0; en8_cnt = 0; wren_cnt = 0;
    push_pass(0, 0);
    ret_cnt = 0;
    start_pass();
    wait_done("backpressure");
    check("bp_en_cycles", 64'(en8_cnt), 64'd4);
    check("bp_wren_cycles", 64'(wren_cnt), 64'(BC));
    bp_mode = 0;

    // Miscompare on read return 2
    rand_rdy = 1; flip_mode = 1;
    push_pass(1, 0);
    ret_cnt = 0;
    start_pass();
    wait_done("miscompare");
    check("miscompare_flag", 64'(tg_err), 64'd1);
    check("miscompare_err", 64'(err_count), 64'(ref_err));
    flip_mode = 0;

    // Reset in the middle of the write phase
    rand_rdy = 0;
    push_pass(0, 0);
    start_pass();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (app.app_en && app.app_addr == AW'(2 * STEP)) break;
      lat++;
    end
    if (lat == 20) fail_event("midreset_write2_missing");
    saved_done = n_done;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_en", 64'(app.app_en), 64'd0);
    check("midreset_wren", 64'(app.app_wdf_wren), 64'd0);
    do_reset(2);
    repeat (5) @(negedge clk);
    check("midreset_pass_count", 64'(pass_count), 64'd0);
    check("midreset_no_done", 64'(n_done), 64'(saved_done));
    check("midreset_busy", 64'(busy), 64'd0);

    // Read timeout: no returns at all
    noret_mode = 1;
    push_pass(0, 1);
    start_pass();
    wait_done("timeout");
    // DONE is entered TMO edges after the last read is accepted; done follows one edge later.
    check("timeout_latency", 64'(done_cyc - last_rd_acc), 64'(TMO + 1));
    check("timeout_flag", 64'(tg_err), 64'd1);
    check("timeout_err_count", 64'(err_count), 64'd0);
    noret_mode = 0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
